dram_rd_p2s_model: RTL and testbench
====================================

Name: dram_rd_p2s_model

Overview:
Chip-side model of the DRAM read-out parallel-to-serial shift chain: the transmitting end of the PC_data / DRAM16_data read interface.
- Accepts one 16×8-bit read word (one byte per DRAM chip) through a valid/ready handshake.
- Loads it under SR/LD# and shifts it out MSB-first on 16 serial lines, reacting to the PC shift clock sampled in the system domain.
- Used for FPGA loopback bring-up and as the bench responder for the read/write controller's receive path.

Parameters:
- N_CH, 16, number of chips / serial lines.
- WORD_W, 8, bits per chip word.
- SYNC_STAGES, 2, synchroniser depth on pc_data inputs (≥2).
- FILL_BIT, 1'b0, serial-in value shifted into the LSB.

Ports:
- clk_100m  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- par_data  in  N_CH*WORD_W  read word; chip k (1..N_CH) = par_data[k*WORD_W-1 -: WORD_W].
- par_valid  in  1  par_data valid.
- par_ready  out  1  hold register can accept.
- pc_data  in  3  [0] shift clock, [1] SR/LD# (0 = load), [2] CLK_INV (1 = falling edge active).
- ser_data  out  N_CH  serial bit per chip, ser_data[k] = MSB of chip k shift register.
- word_done  out  1  one-cycle pulse when the last bit of a word becomes visible.
- underrun  out  1  sticky: load occurred with hold register empty.
- overrun  out  1  sticky: shift edge after word complete.
- shift_cnt  out  log2(WORD_W)+1  shifts since last load.

Behaviour:
- Reset (async, rst=1): ser_data=0, par_ready=1, word_done=0, underrun=0, overrun=0, shift_cnt=0, hold empty, state=IDLE, synchronisers=0.
- Input conditioning:
  - All three pc_data bits pass through SYNC_STAGES flops.
  - Active edge = rising edge of synced pc_data[0] XOR synced pc_data[2].
  - A CLK_INV change is not itself an edge: edge detect compares the raw synced clock, and the polarity selects which transition counts.
- Hold register (1 deep):
  - Written when par_valid & par_ready.
  - par_ready = !hold_full | consume, where consume is the load-release cycle defined below.
  - Accept and consume in the same cycle: the new word is stored and hold stays full.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - Any state → LOAD when synced LD#=0.
  - While in LOAD, every cycle: shift registers ← hold (or all-zero if hold empty), shift_cnt=0, and active edges are ignored (load dominates).
  - LOAD → SHIFT on LD# 0→1. That cycle is the consume cycle: hold is freed. If hold was empty at release, underrun is set and the zero word stays loaded.
  - SHIFT: each active edge shifts every channel left by 1, inserts FILL_BIT at the LSB, and increments shift_cnt.
  - SHIFT → DONE on the edge that makes shift_cnt = WORD_W-1; word_done pulses that cycle. The bit-0 value is now on ser_data.
  - DONE: further active edges keep shifting (FILL_BIT propagates), set overrun, and saturate shift_cnt at WORD_W.
  - LD# low in SHIFT before completion aborts the word: no word_done pulse, no flag set.
  - IDLE → LOAD only; edges in IDLE are ignored.
- Latency:
  - ser_data changes SYNC_STAGES+1 clk_100m cycles after a pin-level active edge.
  - On load, MSB (bit WORD_W-1) appears SYNC_STAGES+1 cycles after LD# falls.
- Pin timing: the receiver must hold each pc_data level ≥2 clk_100m cycles; narrower pulses are not guaranteed to be seen.
- Outputs are fully registered; no combinational path from inputs to ser_data.
- Flags clear only on reset.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/LOAD/SHIFT/DONE).
  - Channel slice helper constant CH_LSB(k) = (k-1)*WORD_W.
  - Default N_CH/WORD_W constants shared with the receiver.
- One natural sub-module: pc_edge_sync. It contains the SYNC_STAGES synchroniser plus the polarity-selectable edge detector, and outputs ld_n_s and shift_edge.
- The per-channel shift registers remain inline (generate loop).

Test Plan:
- Load 0x55 on all 16 chips, LD# low 4 cycles then high, 7 rising edges → ser_data steps 16'h0000, FFFF, 0000, … alternating. word_done pulses once on the 7th edge; shift_cnt=7.
- chip k = k (1..16), CLK_INV=1, 7 falling edges → serial bits per line reconstruct 0x01..0x10. Rising edges produce no shift.
- Release LD# with no word accepted → underrun=1, ser_data=0 throughout, par_ready stays 1.
- Complete a word, apply 2 extra edges → overrun=1, ser_data=FILL_BIT on all lines, shift_cnt=8.
- Assert LD# after 3 shifts with a new word (0xA3) in hold → no word_done, MSB of 0xA3 (16'hFFFF) appears. The remaining 7 edges yield A3 bit order.
- Assert rst mid-SHIFT → all outputs return to reset values immediately; after release, hold is empty and par_ready=1.

Source files
------------

// File: rtl/dram_rd_p2s_model_pkg.sv
// rtl/dram_rd_p2s_model_pkg.sv - shared types and constants for the DRAM read-out P2S model
package dram_rd_p2s_model_pkg;

    localparam int N_CH_DEF   = 16;
    localparam int WORD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } p2s_state_t;

    // Chip k (1-based) occupies bits [ch_lsb(k) +: word_w] of the flat read word
    function automatic int ch_lsb(input int k, input int word_w);
        return (k - 1) * word_w;
    endfunction

endpackage

// File: rtl/dram_rd_p2s_model_pc_edge_sync.sv
// rtl/dram_rd_p2s_model_pc_edge_sync.sv - pc_data synchroniser and polarity-selectable shift-edge detector
module dram_rd_p2s_model_pc_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_100m,
    input  logic       rst,
    input  logic [2:0] pc_data,
    output logic       ld_n_s,
    output logic       ld_fall,
    output logic       shift_edge
);

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        clk_prev;
    logic                        ld_prev;
    logic                        clk_s;
    logic                        inv_s;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            clk_prev <= 1'b0;
            ld_prev  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pc_data};
            clk_prev <= sync_q[SYNC_STAGES-1][0];
            ld_prev  <= sync_q[SYNC_STAGES-1][1];
        end
    end

    assign clk_s  = sync_q[SYNC_STAGES-1][0];
    assign inv_s  = sync_q[SYNC_STAGES-1][2];
    assign ld_n_s = sync_q[SYNC_STAGES-1][1];

    // Polarity only picks which raw-clock transition counts; toggling CLK_INV alone is never an edge
    assign shift_edge = inv_s ? (clk_prev & ~clk_s) : (~clk_prev & clk_s);

    // The LD# chain resets low, so leaving IDLE needs a genuine high-to-low transition
    assign ld_fall = ld_prev & ~ld_n_s;

endmodule

// File: rtl/dram_rd_p2s_model.sv
// rtl/dram_rd_p2s_model.sv - DRAM read-out parallel-to-serial shift chain, chip-side model
module dram_rd_p2s_model
    import dram_rd_p2s_model_pkg::*;
#(
    parameter int   N_CH        = N_CH_DEF,
    parameter int   WORD_W      = WORD_W_DEF,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_BIT    = 1'b0
) (
    input  logic                     clk_100m,
    input  logic                     rst,
    input  logic [N_CH*WORD_W-1:0]   par_data,
    input  logic                     par_valid,
    output logic                     par_ready,
    input  logic [2:0]               pc_data,
    output logic [N_CH-1:0]          ser_data,
    output logic                     word_done,
    output logic                     underrun,
    output logic                     overrun,
    output logic [$clog2(WORD_W):0]  shift_cnt
);

    localparam int                CNT_W        = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_PRE_LAST = CNT_W'(WORD_W - 2);

    logic                    ld_n_s;
    logic                    ld_fall;
    logic                    shift_edge;
    p2s_state_t              state;
    p2s_state_t              state_nxt;
    logic                    do_load;
    logic                    do_shift;
    logic                    consume;
    logic                    last_shift;
    logic [N_CH*WORD_W-1:0]  hold_q;
    logic                    hold_full;
    logic [N_CH*WORD_W-1:0]  sreg;
    logic [N_CH*WORD_W-1:0]  sreg_sh;

    dram_rd_p2s_model_pc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pc_edge_sync (
        .clk_100m   (clk_100m),
        .rst        (rst),
        .pc_data    (pc_data),
        .ld_n_s     (ld_n_s),
        .ld_fall    (ld_fall),
        .shift_edge (shift_edge)
    );

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        consume    = 1'b0;
        last_shift = 1'b0;
        if (!ld_n_s && (state != ST_IDLE || ld_fall)) begin
            state_nxt = ST_LOAD;
            do_load   = 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    // Release cycle reloads from hold so a word accepted late in LOAD is not lost
                    state_nxt = ST_SHIFT;
                    consume   = 1'b1;
                    do_load   = 1'b1;
                end
                ST_SHIFT: begin
                    if (shift_edge) begin
                        do_shift = 1'b1;
                        if (shift_cnt == CNT_PRE_LAST) begin
                            state_nxt  = ST_DONE;
                            last_shift = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    do_shift = shift_edge;
                end
                default: ;
            endcase
        end
    end

    assign par_ready = ~hold_full | consume;

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (par_valid && par_ready) begin
            hold_q    <= par_data;
            hold_full <= 1'b1;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            shift_cnt <= '0;
            word_done <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            word_done <= last_shift;
            if (do_load) begin
                sreg      <= hold_full ? hold_q : '0;
                shift_cnt <= '0;
            end else if (do_shift) begin
                sreg      <= sreg_sh;
                shift_cnt <= (shift_cnt == CNT_SAT) ? CNT_SAT : shift_cnt + CNT_W'(1);
            end
            if (consume && !hold_full)
                underrun <= 1'b1;
            if (do_shift && state == ST_DONE)
                overrun <= 1'b1;
        end
    end

    for (genvar k = 1; k <= N_CH; k++) begin : g_ch
        assign sreg_sh[ch_lsb(k, WORD_W) +: WORD_W] = {sreg[ch_lsb(k, WORD_W) +: WORD_W-1], FILL_BIT};
        assign ser_data[k-1] = sreg[ch_lsb(k, WORD_W) + WORD_W - 1];
    end

endmodule

// File: tb/tb_dram_rd_p2s_model.sv
// tb/tb_dram_rd_p2s_model.sv - scoreboard bench for dram_rd_p2s_model
module tb_dram_rd_p2s_model;

    localparam int N_CH   = 16;
    localparam int WORD_W = 8;
    localparam int LAT    = 3;

    logic                    clk_100m = 1'b0;
    logic                    rst      = 1'b1;
    logic [N_CH*WORD_W-1:0]  par_data = '0;
    logic                    par_valid = 1'b0;
    logic                    par_ready;
    logic [2:0]              pc_data  = 3'b010;
    logic [N_CH-1:0]         ser_data;
    logic                    word_done;
    logic                    underrun;
    logic                    overrun;
    logic [$clog2(WORD_W):0] shift_cnt;

    always #5 clk_100m = ~clk_100m;

    dram_rd_p2s_model dut (
        .clk_100m  (clk_100m),
        .rst       (rst),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .pc_data   (pc_data),
        .ser_data  (ser_data),
        .word_done (word_done),
        .underrun  (underrun),
        .overrun   (overrun),
        .shift_cnt (shift_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    typedef struct {
        logic [N_CH-1:0] val;
        int              at;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: loaded word per chip plus number of active edges since load
    logic [WORD_W-1:0] stim[N_CH];
    logic [WORD_W-1:0] m_word[N_CH];
    logic [WORD_W-1:0] m_hold[N_CH];
    bit                m_hold_full = 0;
    bit                m_active = 0;
    bit                m_under = 0;
    bit                m_over = 0;
    int                m_n = 0;
    int                m_done = 0;
    logic [N_CH-1:0]   m_ser = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [N_CH-1:0] model_ser();
        logic [N_CH-1:0] v;
        for (int k = 0; k < N_CH; k++)
            v[k] = (m_n < WORD_W) ? m_word[k][WORD_W-1-m_n] : 1'b0;
        return v;
    endfunction

    task automatic push_if_changed(input int at);
        logic [N_CH-1:0] nv;
        nv = model_ser();
        if (nv !== m_ser) begin
            exp_q.push_back('{nv, at});
            m_ser = nv;
        end
    endtask

    bit              mon_en = 0;
    logic [N_CH-1:0] last_ser = '0;
    int              done_seen = 0;

    always @(negedge clk_100m) begin
        if (mon_en) begin
            if (word_done === 1'b1) done_seen++;
            if (ser_data !== last_ser) begin
                if (exp_q.size() == 0) begin
                    chk("ser_unexpected_change", ser_data, last_ser);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ser_value", ser_data, e.val);
                    chk("ser_latency", cyc, e.at);
                end
                last_ser = ser_data;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_100m);
        #1;
    endtask

    task automatic toggle_clk();
        bit active;
        active = (!pc_data[0]) ^ pc_data[2];
        pc_data[0] = ~pc_data[0];
        if (active && m_active) begin
            m_n++;
            if (m_n == WORD_W - 1) m_done++;
            if (m_n >= WORD_W) m_over = 1;
            push_if_changed(cyc + LAT);
        end
        wait_cyc(3);
    endtask

    task automatic active_edge();
        if (pc_data[0] != pc_data[2]) toggle_clk();
        toggle_clk();
    endtask

    task automatic set_inv(input bit v);
        pc_data[2] = v;
        wait_cyc(3);
    endtask

    task automatic accept();
        for (int k = 0; k < N_CH; k++) par_data[k*WORD_W +: WORD_W] = stim[k];
        par_valid = 1'b1;
        @(negedge clk_100m);
        chk("par_ready_at_accept", par_ready, 1'b1);
        wait_cyc(1);
        par_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) m_hold[k] = stim[k];
        m_hold_full = 1;
        wait_cyc(1);
    endtask

    task automatic load_word(input int low_cycles);
        pc_data[1] = 1'b0;
        for (int k = 0; k < N_CH; k++) m_word[k] = m_hold_full ? m_hold[k] : '0;
        m_n = 0;
        m_active = 0;
        push_if_changed(cyc + LAT);
        wait_cyc(low_cycles);
        pc_data[1] = 1'b1;
        if (!m_hold_full) m_under = 1;
        m_hold_full = 0;
        m_active = 1;
        wait_cyc(3);
    endtask

    task automatic checkpoint(input string name);
        wait_cyc(1);
        @(negedge clk_100m);
        #1;
        $display("checkpoint %s", name);
        chk("pending_expectations", exp_q.size(), 0);
        chk("shift_cnt", shift_cnt, (m_n > WORD_W) ? WORD_W : m_n);
        chk("underrun", underrun, m_under);
        chk("overrun", overrun, m_over);
        chk("par_ready", par_ready, !m_hold_full);
        chk("word_done_count", done_seen, m_done);
        chk("ser_data", ser_data, m_ser);
        wait_cyc(1);
    endtask

    task automatic reset_now();
        wait_cyc(4);
        rst = 1'b1;
        pc_data = 3'b010;
        m_n = 0;
        m_active = 0;
        m_hold_full = 0;
        m_under = 0;
        m_over = 0;
        for (int k = 0; k < N_CH; k++) m_word[k] = '0;
        push_if_changed(cyc);
        #1;
        chk("rst_ser_data", ser_data, 0);
        chk("rst_shift_cnt", shift_cnt, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_par_ready", par_ready, 1);
        chk("rst_word_done", word_done, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N_CH; k++) m_word[k] = '0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(4);
        mon_en = 1;
        checkpoint("reset");

        for (int k = 0; k < N_CH; k++) stim[k] = 8'h55;
        accept();
        chk("par_ready_when_full", par_ready, 1'b0);
        load_word(4);
        repeat (7) active_edge();
        checkpoint("alternating_55");

        set_inv(1'b1);
        for (int k = 0; k < N_CH; k++) stim[k] = WORD_W'(k + 1);
        accept();
        load_word(3);
        repeat (7) active_edge();
        checkpoint("clk_inv_chip_index");

        load_word(3);
        repeat (3) active_edge();
        checkpoint("underrun");

        set_inv(1'b0);
        for (int k = 0; k < N_CH; k++) stim[k] = WORD_W'($urandom);
        accept();
        load_word(2);
        repeat (9) active_edge();
        checkpoint("overrun");

        for (int k = 0; k < N_CH; k++) stim[k] = WORD_W'($urandom);
        accept();
        load_word(3);
        repeat (3) active_edge();
        for (int k = 0; k < N_CH; k++) stim[k] = 8'hA3;
        accept();
        load_word(3);
        checkpoint("abort_reload");
        repeat (7) active_edge();
        checkpoint("a3_after_abort");

        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < N_CH; k++) stim[k] = WORD_W'($urandom);
            if ($urandom_range(0, 3) != 0) accept();
            set_inv(1'($urandom_range(0, 1)));
            load_word($urandom_range(2, 5));
            repeat ($urandom_range(0, 10)) active_edge();
            checkpoint("random");
        end

        set_inv(1'b0);
        for (int k = 0; k < N_CH; k++) stim[k] = WORD_W'($urandom);
        accept();
        load_word(3);
        repeat (3) active_edge();
        reset_now();
        checkpoint("after_reset");
        load_word(3);
        checkpoint("hold_empty_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
